// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage constants: branch/jump op encodings and PC step.
package riscv_pkg;
    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b010;
    localparam logic [2:0] OP_BLTU = 3'b011;
    localparam logic [2:0] OP_BGE  = 3'b100;
    localparam logic [2:0] OP_BGEU = 3'b101;
    localparam logic [2:0] OP_JAL  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam int PC_STEP = 4;
endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation; jumps report always-true.
module branch_cond
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond_true
);
    logic eq, lt_s, lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_u = (rs1 < rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));

    always_comb begin
        cond_true = 1'b0;
        case (op)
            OP_BEQ:  cond_true = eq;
            OP_BNE:  cond_true = !eq;
            OP_BLT:  cond_true = lt_s;
            OP_BLTU: cond_true = lt_u;
            OP_BGE:  cond_true = !lt_s;
            OP_BGEU: cond_true = !lt_u;
            default: cond_true = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution stage: direction, next PC, mispredict and
// misalign detection, plus saturating branch/mispredict statistics.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  link,
    output logic             mispredict,
    output logic             misalign,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);
    logic            cond_true;
    logic [XLEN-1:0] target_c, seq_pc_c, jalr_sum;
    logic            mispred_c, accept, is_branch;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .cond_true (cond_true)
    );

    assign jalr_sum  = rs1 + imm;
    assign target_c  = (op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
    assign seq_pc_c  = pc + XLEN'(PC_STEP);
    // pred_target only matters when the branch actually resolves taken
    assign mispred_c = (cond_true != pred_taken) || (cond_true && (pred_target != target_c));
    assign is_branch = (op <= OP_BGEU);

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            next_pc     <= '0;
            link        <= '0;
            mispredict  <= 1'b0;
            misalign    <= 1'b0;
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                taken      <= cond_true;
                next_pc    <= cond_true ? target_c : seq_pc_c;
                link       <= seq_pc_c;
                mispredict <= mispred_c;
                misalign   <= cond_true && target_c[1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // clear wins over a same-cycle increment; both stick at all-ones
            if (cnt_clr) begin
                cnt_branch  <= '0;
                cnt_mispred <= '0;
            end else if (accept) begin
                if (is_branch && (cnt_branch != '1))
                    cnt_branch <= cnt_branch + 1'b1;
                if (mispred_c && (cnt_mispred != '1))
                    cnt_mispred <= cnt_mispred + 1'b1;
            end
        end
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Registered, handshaked branch and jump resolution stage for the execute pipeline, sitting between the operand-read stage and the PC-redirect/fetch logic.
- Evaluates all six conditional branch conditions at width XLEN, plus JAL and JALR.
- Computes the resolved next PC and detects mispredictions against the front-end prediction.
- Flags misaligned targets.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, operand, PC and immediate width (≥8).
CNT_W, 16, width of each statistics counter.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RSTn  in  1  asynchronous, active-low reset.
flush  in  1  synchronous pipeline kill.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request this cycle.
op  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BLTU, 100 BGE, 101 BGEU, 110 JAL, 111 JALR.
rs1  in  XLEN  operand 1.
rs2  in  XLEN  operand 2.
pc  in  XLEN  PC of the instruction.
imm  in  XLEN  sign-extended offset.
pred_taken  in  1  front-end predicted taken.
pred_target  in  XLEN  front-end predicted target.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
taken  out  1  resolved direction.
next_pc  out  XLEN  resolved next PC.
link  out  XLEN  pc+4, for JAL/JALR writeback.
mispredict  out  1  front-end must redirect to next_pc.
misalign  out  1  taken target has bit[1] set.
cnt_clr  in  1  synchronous clear of both counters.
cnt_branch  out  CNT_W  accepted conditional branches.
cnt_mispred  out  CNT_W  accepted mispredictions, all ops.

Behaviour:
- Reset (RSTn=0, async): out_valid=0; taken, next_pc, link, mispredict, misalign = 0; both counters = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no skid buffer).
  - Accept on in_valid && in_ready && !flush; the result is registered the next cycle, giving 1-cycle latency.
  - Outputs hold stable while out_valid && !out_ready.
- Back-to-back: out_valid && out_ready && in_valid gives one result per cycle, full throughput.
- flush=1: out_valid cleared next cycle; any concurrent input is dropped; counters are not updated for the dropped input.
- Conditions:
  - BEQ / BNE: rs1 == rs2 and rs1 != rs2.
  - BLT / BGE: signed comparison over XLEN bits.
  - BLTU / BGEU: unsigned comparison.
  - JAL / JALR: always taken.
- Targets:
  - Branch and JAL: pc + imm, modulo 2^XLEN (wrap-around, no overflow flag).
  - JALR: (rs1 + imm) with bit[0] forced to 0.
- next_pc = taken ? target : pc + 4, with wrap-around; link = pc + 4.
- mispredict = (taken != pred_taken) || (taken && pred_target != target). When not taken, pred_target is ignored.
- misalign = taken && target[1]. next_pc still carries the target; the trap decision is made downstream.
- Counters:
  - On an accepted request, cnt_branch increments if op ≤ 101, and cnt_mispred increments if mispredict is computed true.
  - Both counters saturate at all-ones and do not wrap.
  - cnt_clr has priority over an increment in the same cycle.
  - flush does not clear the counters.
- Reset asserted mid-operation: the pending result is discarded and the unit is ready immediately after RSTn deasserts.

Decomposition:
- Shared package (riscv_pkg): op encodings BEQ..JALR as 3-bit localparams; the constant PC_STEP = 4.
- One natural sub-module, branch_cond: combinational evaluation of op, rs1 and rs2 to cond_true, parametrised by XLEN. It is reused by any future fused compare-and-branch path.
- Counters, target adders and the output register stay in the top module.

Test Plan:
- XLEN=32, BLT with rs1=0xFFFF_FFFF (-1), rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle: taken=1, next_pc=0x120, mispredict=1, cnt_mispred=1.
- BLTU with the same operands, pred_taken=0 -> taken=0, next_pc=0x104, mispredict=0, cnt_branch incremented.
- JALR with rs1=0x203, imm=0 -> next_pc=0x202, misalign=1, link=pc+4, cnt_branch unchanged.
- out_ready=0 for 3 cycles with a result pending -> in_ready=0, outputs unchanged; out_ready=1 together with a new request -> the new result appears the next cycle.
- flush together with a valid input -> out_valid=0 the next cycle and counters unchanged.
- CNT_W=4: 17 accepted BEQ taken with pred_taken=0 -> both counters hold 0xF; cnt_clr asserted with an accept in the same cycle -> counters = 0.
